write_port_checker: RTL and testbench
=====================================

WRITE_PORT_CHECKER -- requirements
Module: write_port_checker

Interface
REQ-001 Parameter REQUIRED_MATCHES, default 4, range 1..255; number of matching write samples needed to declare pass.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 write_en  input  1  qualifies the port bundle below as a valid write sample this cycle.
REQ-005 clear  input  1  returns a finished checker to IDLE; ignored in IDLE and CHECK.
REQ-006 write_port  input  1  scalar under test; expected 1'b1.
REQ-007 write_quad_port  input  128  wide word under test; expected 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210.
REQ-008 write_array_port [0:127]  input  1 each  expected element i = i[0].
REQ-009 write_quad_array_port [0:127]  input  128 each  expected element i = 128'h0123_4567_89AB_CD00_FEDC_BA98_7654_3200 | {120'b0,i[7:0]} | ({120'b0,i[7:0]} << 64).
REQ-010 done  output  1  checker in PASS or FAIL.
REQ-011 pass  output  1  checker in PASS.
REQ-012 match_count  output  8  matching samples accepted since last IDLE entry.
REQ-013 error_flags  output  4  sticky per-port mismatch: [0] write_port, [1] write_quad_port, [2] write_array_port, [3] write_quad_array_port.
REQ-014 first_fail_index  output  8  lowest failing array index of the failing sample; 8'hFF if no array element failed.
REQ-015 last_quad  output  128  last write_quad_port value sampled with write_en.

Function
REQ-016 States: IDLE, CHECK, PASS, FAIL; state register reset to IDLE.
REQ-017 A sample is evaluated only on a cycle with write_en=1 in IDLE or CHECK; write_en in PASS/FAIL is ignored.
REQ-018 Sample matches when all four ports equal their expected values in full (all 128 elements, all 128 bits).
REQ-019 Matching sample: match_count increments by 1; if new count == REQUIRED_MATCHES, next state PASS, else CHECK.
REQ-020 Mismatching sample: next state FAIL; error_flags set for every failing port; first_fail_index = minimum index failing in either array (both arrays considered), else 8'hFF; match_count holds.
REQ-021 IDLE with write_en=0: stays IDLE; CHECK with write_en=0: stays CHECK, all outputs hold.
REQ-022 last_quad loads write_quad_port on every evaluated sample, match or not.
REQ-023 All outputs registered; effect of a sample visible the cycle after its write_en edge (latency 1).
REQ-024 done=1 in PASS and FAIL; pass=1 only in PASS; both 0 in IDLE and CHECK.
REQ-025 clear=1 in PASS or FAIL: next state IDLE, match_count, error_flags cleared, first_fail_index to 8'hFF; last_quad holds.
REQ-026 clear and write_en together in PASS/FAIL: clear wins, sample discarded.
REQ-027 match_count never exceeds REQUIRED_MATCHES; no wrap.
REQ-028 Comparison of write_quad_array_port is combinational over all 128 elements; no multi-cycle scan.

Reset
REQ-029 reset=1 at a clock edge overrides clear and write_en: state IDLE, done=0, pass=0, match_count=0, error_flags=0, first_fail_index=8'hFF, last_quad=0.
REQ-030 Reset asserted mid-CHECK discards accumulated count; first sample after reset starts a fresh run.

Verification
REQ-031 Drive all expected values, write_en=1 for 4 cycles (default parameter) -> match_count 1,2,3,4; done=pass=1 the cycle after the 4th sample.
REQ-032 Expected values, but write_quad_array_port[37] bit 0 flipped on 2nd sample -> FAIL, error_flags=4'b1000, first_fail_index=37, match_count=1, pass=0.
REQ-033 write_port=0 and write_array_port[5]=0 on 1st sample -> FAIL, error_flags=4'b0101, first_fail_index=5.
REQ-034 Correct samples with write_en toggling 1,0,0,1,1,0,1 -> PASS exactly after 4th asserted write_en; idle cycles do not count.
REQ-035 Reach FAIL, assert clear with write_en=1 -> IDLE, counters cleared, sample ignored; then 4 correct samples -> PASS.
REQ-036 Reset asserted after 2 matching samples -> match_count=0, last_quad=0, state IDLE next cycle; 4 further matches -> PASS.

Source files
------------

// File: rtl/write_port_checker.sv
// ============================================================================
// Module  : write_port_checker
// Brief   : Checks write samples on four ports against fixed expected values.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module write_port_checker #(
  parameter int REQUIRED_MATCHES = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         write_en,
  input  logic         clear,
  input  logic         write_port,
  input  logic [127:0] write_quad_port,
  input  logic         write_array_port      [0:127],
  input  logic [127:0] write_quad_array_port [0:127],
  output logic         done,
  output logic         pass,
  output logic [7:0]   match_count,
  output logic [3:0]   error_flags,
  output logic [7:0]   first_fail_index,
  output logic [127:0] last_quad
);

  localparam logic [127:0] C_QUAD_EXP = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
  localparam logic [127:0] C_QA_BASE  = 128'h0123_4567_89AB_CD00_FEDC_BA98_7654_3200;
  localparam logic [7:0]   C_REQ      = 8'(REQUIRED_MATCHES);
  localparam logic [7:0]   C_NO_FAIL  = 8'hFF;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CHECK = 2'd1,
    S_PASS  = 2'd2,
    S_FAIL  = 2'd3
  } state_t;

  state_t         state_q, state_d;
  logic           done_q, done_d;
  logic           pass_q, pass_d;
  logic [7:0]     match_count_q, match_count_d;
  logic [3:0]     error_flags_q, error_flags_d;
  logic [7:0]     first_fail_index_q, first_fail_index_d;
  logic [127:0]   last_quad_q, last_quad_d;

  logic [127:0]   array_fail;
  logic [127:0]   quad_array_fail;
  logic [3:0]     sample_flags;
  logic [7:0]     fail_index;
  logic [7:0]     count_inc;

  function automatic logic [127:0] quad_array_expected(input logic [7:0] idx);
    return C_QA_BASE | {120'b0, idx} | ({120'b0, idx} << 64);
  endfunction

  // Every element is compared in the same cycle; no scan over the arrays.
  always_comb begin
    array_fail      = '0;
    quad_array_fail = '0;
    for (int i = 0; i < 128; i++) begin
      array_fail[i]      = (write_array_port[i] != 1'(i));
      quad_array_fail[i] = (write_quad_array_port[i] != quad_array_expected(8'(i)));
    end
  end

  // Downward sweep leaves the lowest failing index of either array.
  always_comb begin
    fail_index = C_NO_FAIL;
    for (int i = 127; i >= 0; i--) begin
      if (array_fail[i] || quad_array_fail[i]) begin
        fail_index = 8'(i);
      end
    end
  end

  assign sample_flags = {|quad_array_fail,
                         |array_fail,
                         (write_quad_port != C_QUAD_EXP),
                         (write_port != 1'b1)};
  assign count_inc    = match_count_q + 8'd1;

  always_comb begin
    state_d            = state_q;
    match_count_d      = match_count_q;
    error_flags_d      = error_flags_q;
    first_fail_index_d = first_fail_index_q;
    last_quad_d        = last_quad_q;

    case (state_q)
      S_IDLE, S_CHECK: begin
        if (write_en) begin
          last_quad_d = write_quad_port;
          if (sample_flags == 4'b0000) begin
            match_count_d = count_inc;
            state_d       = (count_inc == C_REQ) ? S_PASS : S_CHECK;
          end else begin
            state_d            = S_FAIL;
            error_flags_d      = error_flags_q | sample_flags;
            first_fail_index_d = fail_index;
          end
        end
      end
      S_PASS, S_FAIL: begin
        // clear takes priority; a simultaneous write sample is dropped.
        if (clear) begin
          state_d            = S_IDLE;
          match_count_d      = 8'd0;
          error_flags_d      = 4'b0000;
          first_fail_index_d = C_NO_FAIL;
        end
      end
      default: state_d = S_IDLE;
    endcase

    done_d = (state_d == S_PASS) || (state_d == S_FAIL);
    pass_d = (state_d == S_PASS);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q            <= S_IDLE;
      done_q             <= 1'b0;
      pass_q             <= 1'b0;
      match_count_q      <= 8'd0;
      error_flags_q      <= 4'b0000;
      first_fail_index_q <= C_NO_FAIL;
      last_quad_q        <= '0;
    end else begin
      state_q            <= state_d;
      done_q             <= done_d;
      pass_q             <= pass_d;
      match_count_q      <= match_count_d;
      error_flags_q      <= error_flags_d;
      first_fail_index_q <= first_fail_index_d;
      last_quad_q        <= last_quad_d;
    end
  end

  assign done             = done_q;
  assign pass             = pass_q;
  assign match_count      = match_count_q;
  assign error_flags      = error_flags_q;
  assign first_fail_index = first_fail_index_q;
  assign last_quad        = last_quad_q;

endmodule

`default_nettype wire

// File: tb/tb_write_port_checker.sv
// ============================================================================
// Module  : tb_write_port_checker
// Brief   : Scoreboard bench for write_port_checker with directed vectors.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module tb_write_port_checker;

  localparam logic [127:0] C_Q    = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
  localparam logic [127:0] C_QA   = 128'h0123_4567_89AB_CD00_FEDC_BA98_7654_3200;
  localparam logic [127:0] C_X    = 128'hDEAD_BEEF_0000_1111_2222_3333_4444_5555;
  localparam logic [7:0]   C_NONE = 8'hFF;

  logic         clk;
  logic         reset;
  logic         write_en;
  logic         clear;
  logic         write_port;
  logic [127:0] write_quad_port;
  logic         write_array_port      [0:127];
  logic [127:0] write_quad_array_port [0:127];
  logic         done;
  logic         pass;
  logic [7:0]   match_count;
  logic [3:0]   error_flags;
  logic [7:0]   first_fail_index;
  logic [127:0] last_quad;

  typedef struct {
    string        tag;
    logic         done;
    logic         pass;
    logic [7:0]   cnt;
    logic [3:0]   flags;
    logic [7:0]   ffi;
    logic [127:0] lq;
  } exp_t;

  exp_t sb[$];
  int   tests_run = 0;
  int   tests_failed = 0;

  write_port_checker #(.REQUIRED_MATCHES(4)) dut (
    .clk                   (clk),
    .reset                 (reset),
    .write_en              (write_en),
    .clear                 (clear),
    .write_port            (write_port),
    .write_quad_port       (write_quad_port),
    .write_array_port      (write_array_port),
    .write_quad_array_port (write_quad_array_port),
    .done                  (done),
    .pass                  (pass),
    .match_count           (match_count),
    .error_flags           (error_flags),
    .first_fail_index      (first_fail_index),
    .last_quad             (last_quad)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input string name,
                       input logic [127:0] act, input logic [127:0] req);
    tests_run++;
    if (act !== req) begin
      tests_failed++;
      $display("FAIL %s %s: actual %0h required %0h", tag, name, act, req);
    end
  endtask

  // Monitor: compares the registered outputs half a cycle after each edge.
  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check(e.tag, "done",             {127'b0, done},             {127'b0, e.done});
      check(e.tag, "pass",             {127'b0, pass},             {127'b0, e.pass});
      check(e.tag, "match_count",      {120'b0, match_count},      {120'b0, e.cnt});
      check(e.tag, "error_flags",      {124'b0, error_flags},      {124'b0, e.flags});
      check(e.tag, "first_fail_index", {120'b0, first_fail_index}, {120'b0, e.ffi});
      check(e.tag, "last_quad",        last_quad,                  e.lq);
    end
  end

  task automatic set_good();
    write_port      = 1'b1;
    write_quad_port = C_Q;
    for (int i = 0; i < 128; i++) begin
      write_array_port[i]      = 1'(i);
      write_quad_array_port[i] = C_QA | {120'b0, 8'(i)} | ({120'b0, 8'(i)} << 64);
    end
  endtask

  task automatic step(input string tag, input logic we, input logic clr, input logic rst,
                      input logic e_done, input logic e_pass, input logic [7:0] e_cnt,
                      input logic [3:0] e_flags, input logic [7:0] e_ffi,
                      input logic [127:0] e_lq);
    exp_t e;
    write_en = we;
    clear    = clr;
    reset    = rst;
    @(posedge clk);
    e.tag = tag; e.done = e_done; e.pass = e_pass; e.cnt = e_cnt;
    e.flags = e_flags; e.ffi = e_ffi; e.lq = e_lq;
    sb.push_back(e);
    @(negedge clk);
  endtask

  initial begin
    reset    = 1'b1;
    write_en = 1'b0;
    clear    = 1'b0;
    set_good();
    @(negedge clk);

    step("reset", 0, 0, 1, 0, 0, 0, 4'b0000, C_NONE, '0);

    // Four good samples reach PASS
    step("p1", 1, 0, 0, 0, 0, 1, 4'b0000, C_NONE, C_Q);
    step("p2", 1, 0, 0, 0, 0, 2, 4'b0000, C_NONE, C_Q);
    step("p3", 1, 0, 0, 0, 0, 3, 4'b0000, C_NONE, C_Q);
    step("p4", 1, 0, 0, 1, 1, 4, 4'b0000, C_NONE, C_Q);
    write_quad_port = C_X;
    step("pass_hold", 1, 0, 0, 1, 1, 4, 4'b0000, C_NONE, C_Q);
    set_good();
    step("clr1", 0, 1, 0, 0, 0, 0, 4'b0000, C_NONE, C_Q);

    // Quad array element 37 bit 0 flipped on second sample
    step("f1", 1, 0, 0, 0, 0, 1, 4'b0000, C_NONE, C_Q);
    write_quad_array_port[37][0] = ~write_quad_array_port[37][0];
    step("f2", 1, 0, 0, 1, 0, 1, 4'b1000, 8'd37, C_Q);
    set_good();
    write_port = 1'b0;
    step("fail_hold", 1, 0, 0, 1, 0, 1, 4'b1000, 8'd37, C_Q);
    set_good();
    step("clr2", 0, 1, 0, 0, 0, 0, 4'b0000, C_NONE, C_Q);

    // Scalar and array element 5 wrong on first sample
    write_port          = 1'b0;
    write_array_port[5] = 1'b0;
    step("w5", 1, 0, 0, 1, 0, 0, 4'b0101, 8'd5, C_Q);

    // clear with write_en: sample discarded, last_quad keeps old value
    write_quad_port = C_X;
    step("clr_we", 1, 1, 0, 0, 0, 0, 4'b0000, C_NONE, C_Q);
    set_good();

    // write_en pattern 1,0,0,1,1,0,1
    step("t1", 1, 0, 0, 0, 0, 1, 4'b0000, C_NONE, C_Q);
    step("t2", 0, 0, 0, 0, 0, 1, 4'b0000, C_NONE, C_Q);
    step("t3", 0, 0, 0, 0, 0, 1, 4'b0000, C_NONE, C_Q);
    step("t4", 1, 0, 0, 0, 0, 2, 4'b0000, C_NONE, C_Q);
    step("t5", 1, 0, 0, 0, 0, 3, 4'b0000, C_NONE, C_Q);
    step("t6", 0, 0, 0, 0, 0, 3, 4'b0000, C_NONE, C_Q);
    step("t7", 1, 0, 0, 1, 1, 4, 4'b0000, C_NONE, C_Q);
    step("clr3", 0, 1, 0, 0, 0, 0, 4'b0000, C_NONE, C_Q);

    // Both arrays and the quad word wrong: lowest index across arrays wins
    write_quad_port               = C_X;
    write_array_port[10]          = ~write_array_port[10];
    write_quad_array_port[3][100] = ~write_quad_array_port[3][100];
    step("multi", 1, 0, 0, 1, 0, 0, 4'b1110, 8'd3, C_X);
    set_good();
    step("clr4", 0, 1, 0, 0, 0, 0, 4'b0000, C_NONE, C_X);

    // Highest array index
    write_array_port[127] = 1'b0;
    step("e127", 1, 0, 0, 1, 0, 0, 4'b0100, 8'd127, C_Q);
    set_good();
    step("clr5", 0, 1, 0, 0, 0, 0, 4'b0000, C_NONE, C_Q);

    // Reset mid-run discards the count and last_quad
    step("m1", 1, 0, 0, 0, 0, 1, 4'b0000, C_NONE, C_Q);
    step("m2", 1, 0, 0, 0, 0, 2, 4'b0000, C_NONE, C_Q);
    step("rst_mid", 1, 0, 1, 0, 0, 0, 4'b0000, C_NONE, '0);
    step("r1", 1, 0, 0, 0, 0, 1, 4'b0000, C_NONE, C_Q);
    step("r2", 1, 0, 0, 0, 0, 2, 4'b0000, C_NONE, C_Q);
    step("r3", 1, 0, 0, 0, 0, 3, 4'b0000, C_NONE, C_Q);
    step("r4", 1, 0, 0, 1, 1, 4, 4'b0000, C_NONE, C_Q);

    write_en = 1'b0;
    @(negedge clk);
    #1;
    tests_run++;
    if (sb.size() != 0) begin
      tests_failed++;
      $display("FAIL scoreboard_drain: actual %0d entries left, required 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

`default_nettype wire
